// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package multicycle_ctrl_pkg;

    // State encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        WB_MEM   = 4'd6,
        MEM_WR   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        FAULT    = 4'd10
    } state_t;

    // Instruction classes produced by the opcode decoder.
    typedef enum logic [2:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BR,
        CLS_BR_COND
    } iclass_t;

    // Opcodes (instr[15:13]); branches are 1x1 (always) and 1x0 (on zero).
    localparam logic [2:0] OP_ALU_R = 3'b000;
    localparam logic [2:0] OP_ALU_I = 3'b001;
    localparam logic [2:0] OP_LDR   = 3'b010;
    localparam logic [2:0] OP_STR   = 3'b011;

    // ALU operand B select.
    localparam logic [1:0] ALUSRCB_REG  = 2'b00;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b01;
    localparam logic [1:0] ALUSRCB_TWO  = 2'b10;

    localparam logic [1:0] ALUCTRL_ADD  = 2'b00;

    // Register-file read-port steering.
    localparam logic [1:0] REGSRC_PC    = 2'b01;
    localparam logic [1:0] REGSRC_RD    = 2'b10;

    // Consecutive not-ready cycles tolerated in a memory state.
    localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode to instruction-class decoder for the multicycle sequencer.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the opcode.
module mc_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [2:0] op,
    output iclass_t    instrClass
);

    // Map opcode to class; op[2] marks branches, op[0] picks unconditional.
    always_comb begin
        instrClass = CLS_ALU_R;
        if (op[2]) begin
            instrClass = op[0] ? CLS_BR : CLS_BR_COND;
        end else begin
            case (op)
                OP_ALU_R: instrClass = CLS_ALU_R;
                OP_ALU_I: instrClass = CLS_ALU_I;
                OP_LDR:   instrClass = CLS_LOAD;
                OP_STR:   instrClass = CLS_STORE;
                default:  instrClass = CLS_ALU_R;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath muxes and the shared memory port.
// Latency (zero-wait memory): ALU 4, load 5, store 4, taken branch 3, not-taken branch 2 cycles.
// Backpressure: memory states stall on mem_ready; optional timeout traps to sticky FAULT.
// Optional perf counters cyc_cnt/ret_cnt are built when MCCTRL_PERF_EN is defined.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
`ifdef MCCTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        flag_z,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  reg_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_ctrl,
    output logic        result_src,
    output logic        retire,
    output logic        fault,
    output logic [3:0]  state_o
`ifdef MCCTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state;
    iclass_t         instrClass;
    logic [TO_W-1:0] waitCnt;
    logic            memState;
    logic            timeoutHit;

    // Register/immediate fields are consumed by the datapath, not here.
    logic unusedInstrBits;
    assign unusedInstrBits = ^instr[12:2];

    mc_ctrl_decode uDecode (
        .op         (instr[15:13]),
        .instrClass (instrClass)
    );

    assign memState   = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign timeoutHit = (MEM_TIMEOUT != 0) && memState && !mem_ready && (waitCnt == TO_LAST);

    // State sequencing plus the memory wait counter, which restarts whenever a wait ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            waitCnt <= '0;
        end else begin
            if (memState && !mem_ready) begin
                waitCnt <= waitCnt + 1'b1;
            end else begin
                waitCnt <= '0;
            end

            case (state)
                FETCH: begin
                    if (mem_ready)       state <= DECODE;
                    else if (timeoutHit) state <= FAULT;
                end
                DECODE: begin
                    case (instrClass)
                        CLS_ALU_R:   state <= EXEC_R;
                        CLS_ALU_I:   state <= EXEC_I;
                        CLS_LOAD:    state <= MEM_ADDR;
                        CLS_STORE:   state <= MEM_ADDR;
                        CLS_BR:      state <= BRANCH;
                        CLS_BR_COND: state <= flag_z ? BRANCH : FETCH;
                        default:     state <= FETCH;
                    endcase
                end
                EXEC_R, EXEC_I: state <= WB_ALU;
                MEM_ADDR: state <= (instrClass == CLS_STORE) ? MEM_WR : MEM_RD;
                MEM_RD: begin
                    if (mem_ready)       state <= WB_MEM;
                    else if (timeoutHit) state <= FAULT;
                end
                MEM_WR: begin
                    if (mem_ready)       state <= FETCH;
                    else if (timeoutHit) state <= FAULT;
                end
                WB_ALU, WB_MEM, BRANCH: state <= FETCH;
                FAULT:   state <= FAULT;
                default: state <= FETCH;
            endcase
        end
    end

    // Control outputs: Moore per state, with the FETCH strobes and DECODE/MEM_WR retire
    // following mem_ready/flag_z in the same cycle; everything is forced low during reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_src    = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUSRCB_REG;
        alu_ctrl   = ALUCTRL_ADD;
        result_src = 1'b0;
        retire     = 1'b0;
        fault      = 1'b0;
        state_o    = 4'd0;
        if (!reset) begin
            state_o = state;
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = ALUSRCB_TWO;
                    end
                end
                DECODE: begin
                    retire = (instrClass == CLS_BR_COND) && !flag_z;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = instr[1:0];
                end
                EXEC_I, MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUSRCB_IMM;
                end
                WB_ALU: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    result_src = 1'b1;
                    retire     = 1'b1;
                end
                MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    reg_src = REGSRC_RD;
                    retire  = mem_ready;
                end
                BRANCH: begin
                    reg_src   = REGSRC_PC;
                    alu_src_b = ALUSRCB_IMM;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
                FAULT: begin
                    fault = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MCCTRL_PERF_EN
    // Saturating cycle and retire counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if ((state != FAULT) && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + 1'b1;
            if (retire && (ret_cnt != '1))           ret_cnt <= ret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle comparison of the full control vector.
// Latency: n/a.
// Backpressure: mem_ready patterns are driven per scenario.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        flag_z;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  reg_src, alu_src_b, alu_ctrl;
    logic        alu_src_a, result_src, retire, fault;
    logic [3:0]  state_o;
`ifdef MCCTRL_PERF_EN
    logic [3:0]  cyc_cnt, ret_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .MEM_TIMEOUT(4)
`ifdef MCCTRL_PERF_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .flag_z     (flag_z),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .reg_src    (reg_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .result_src (result_src),
        .retire     (retire),
        .fault      (fault),
        .state_o    (state_o)
`ifdef MCCTRL_PERF_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .ret_cnt    (ret_cnt)
`endif
    );

    logic [19:0] outs;
    assign outs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, reg_src,
                   alu_src_a, alu_src_b, alu_ctrl, result_src, retire, fault, state_o};

    // Pack named expected fields in the same order as outs.
    function automatic logic [19:0] ev(input logic [3:0] st, input logic mreq, input logic mwe,
                                       input logic adr, input logic irw, input logic pcw,
                                       input logic rw, input logic [1:0] rsrc, input logic a,
                                       input logic [1:0] b, input logic [1:0] ctrl,
                                       input logic rsel, input logic ret, input logic flt);
        return {mreq, mwe, adr, irw, pcw, rw, rsrc, a, b, ctrl, rsel, ret, flt, st};
    endfunction

    logic [19:0] E_ZERO, E_FRDY, E_FWAIT, E_DEC, E_DECRET, E_EXR, E_EXI, E_WBA;
    logic [19:0] E_MA, E_MR, E_WBM, E_MWWAIT, E_MWRDY, E_BR, E_FLT;

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; flag_z = 1'b1; instr = 16'h0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (outs !== E_ZERO) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", outs, E_ZERO);
        end
        reset = 1'b0; flag_z = 1'b0;
    endtask

    task automatic test_alu_r();
        logic [19:0] e [4];
        e = '{E_FRDY, E_DEC, E_EXR, E_WBA};
        instr = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL alu_r cyc%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_i();
        logic [19:0] e [4];
        e = '{E_FRDY, E_DEC, E_EXI, E_WBA};
        instr = 16'h2003;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL alu_i cyc%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        logic [19:0] e [8];
        logic        rdy [8];
        e   = '{E_FRDY, E_DEC, E_MA, E_MR, E_MR, E_MR, E_MR, E_WBM};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        instr = 16'h4000;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i]; #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL load cyc%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        logic [19:0] e [4];
        e = '{E_FRDY, E_DEC, E_MA, E_MWRDY};
        instr = 16'h6000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL store cyc%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [19:0] e  [8];
        logic [15:0] ins[8];
        logic        fz [8];
        e   = '{E_FRDY, E_DECRET, E_FRDY, E_DEC, E_BR, E_FRDY, E_DEC, E_BR};
        ins = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hA000, 16'hA000, 16'hA000};
        fz  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            mem_ready = 1'b1; instr = ins[i]; flag_z = fz[i]; #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL branch cyc%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        flag_z = 1'b0;
    endtask

    task automatic test_timeout();
        logic [19:0] e   [9];
        logic        rdy [9];
        logic        rst [9];
        e   = '{E_FWAIT, E_FWAIT, E_FWAIT, E_FWAIT, E_FLT, E_FLT, E_FLT, E_ZERO, E_FWAIT};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        instr = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i]; reset = rst[i]; #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL timeout cyc%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        logic [19:0] e   [6];
        logic        rdy [6];
        logic        rst [6];
        e   = '{E_FRDY, E_DEC, E_MA, E_MWWAIT, E_ZERO, E_FWAIT};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        instr = 16'h6000;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i]; reset = rst[i]; #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL reset_mid_store cyc%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

`ifdef MCCTRL_PERF_EN
    task automatic test_back_to_back();
        reset = 1'b1; mem_ready = 1'b1; instr = 16'h6000;
        @(posedge clk); #1;
        checks++;
        if (ret_cnt !== 4'd0) begin
            errors++; $display("FAIL perf_ret_reset got %0d exp 0", ret_cnt);
        end
        reset = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        checks++;
        if (ret_cnt !== 4'd10) begin
            errors++; $display("FAIL perf_ret_10 got %0d exp 10", ret_cnt);
        end
        checks++;
        if (cyc_cnt !== 4'd15) begin
            errors++; $display("FAIL perf_cyc_sat got %0d exp 15", cyc_cnt);
        end
        repeat (24) begin @(posedge clk); #1; end
        checks++;
        if (ret_cnt !== 4'd15) begin
            errors++; $display("FAIL perf_ret_sat got %0d exp 15", ret_cnt);
        end
    endtask
`endif

    initial begin
        E_ZERO   = '0;
        E_FRDY   = ev(4'd0,  1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b10, 2'b00, 0, 0, 0);
        E_FWAIT  = ev(4'd0,  1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
        E_DEC    = ev(4'd1,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
        E_DECRET = ev(4'd1,  0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0);
        E_EXR    = ev(4'd2,  0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 0, 0);
        E_EXI    = ev(4'd3,  0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0);
        E_MA     = ev(4'd4,  0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0);
        E_MR     = ev(4'd5,  1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
        E_WBM    = ev(4'd6,  0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 1, 1, 0);
        E_MWWAIT = ev(4'd7,  1, 1, 1, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);
        E_MWRDY  = ev(4'd7,  1, 1, 1, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 1, 0);
        E_WBA    = ev(4'd8,  0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 1, 0);
        E_BR     = ev(4'd9,  0, 0, 0, 0, 1, 0, 2'b01, 0, 2'b01, 2'b00, 0, 1, 0);
        E_FLT    = ev(4'd10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1);

        test_reset();
        test_alu_r();
        test_alu_i();
        test_load();
        test_store();
        test_branch();
        test_timeout();
        test_reset_mid_store();
`ifdef MCCTRL_PERF_EN
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
